// File: rtl/cpu_scoreboard_if.sv
// Decode-side bundle of the Falcon hazard/bypass scoreboard: p2 operand info in,
// bypass selects, bubble request and writeback strobe out.
interface cpu_scoreboard_if #(
   parameter int LAT_BITS = 2,
   parameter int SEL_BITS = 2
);
   logic                stall;
   logic                flush;
   logic                p2_valid;
   logic [4:0]          p2_reg_a;
   logic                p2_use_a;
   logic [4:0]          p2_reg_b;
   logic                p2_use_b;
   logic [4:0]          p2_reg_d;
   logic                p2_write_en;
   logic [LAT_BITS-1:0] p2_latency;
   logic                p2_bubble;
   logic [SEL_BITS-1:0] p2_sel_a;
   logic [SEL_BITS-1:0] p2_sel_b;
   logic [4:0]          wb_reg_d;
   logic                wb_write_en;
   logic [31:0]         bubble_count;

   modport master (
      output stall, flush, p2_valid, p2_reg_a, p2_use_a, p2_reg_b, p2_use_b,
             p2_reg_d, p2_write_en, p2_latency,
      input  p2_bubble, p2_sel_a, p2_sel_b, wb_reg_d, wb_write_en, bubble_count
   );

   modport slave (
      input  stall, flush, p2_valid, p2_reg_a, p2_use_a, p2_reg_b, p2_use_b,
             p2_reg_d, p2_write_en, p2_latency,
      output p2_bubble, p2_sel_a, p2_sel_b, wb_reg_d, wb_write_en, bubble_count
   );
endinterface

// File: rtl/cpu_scoreboard.sv
// Hazard, bypass and writeback tracker: shifts p2 destination entries through
// DEPTH post-decode stages and resolves operand bypass selects against them.
module cpu_scoreboard #(
   parameter int DEPTH       = 3,
   parameter int LAT_BITS    = 2,
   parameter int FLUSH_DEPTH = 1,
   parameter int SEL_BITS    = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   cpu_scoreboard_if.slave bus
);

   typedef struct packed {
      logic                valid;
      logic [4:0]          reg_d;
      logic                write_en;
      logic [LAT_BITS-1:0] latency;
   } entry_t;

   // Index i holds stage p(3+i); index DEPTH-1 is writeback.
   entry_t        stage_q [DEPTH];
   entry_t        stage_d [DEPTH];
   logic [31:0]   bubble_count_q;
   logic [31:0]   bubble_count_d;

   logic                hazard_a;
   logic                hazard_b;
   logic [SEL_BITS-1:0] sel_a;
   logic [SEL_BITS-1:0] sel_b;
   logic                bubble;
   logic                kill_p2;

   // Walk oldest to youngest so the youngest matching stage has the final say.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      sel_a    = '0;
      sel_b    = '0;
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (bus.p2_valid && bus.p2_use_a && stage_q[i].valid && stage_q[i].write_en &&
             stage_q[i].reg_d == bus.p2_reg_a) begin
            if (i >= int'(stage_q[i].latency)) begin
               sel_a    = SEL_BITS'(i + 1);
               hazard_a = 1'b0;
            end else begin
               sel_a    = '0;
               hazard_a = 1'b1;
            end
         end
         if (bus.p2_valid && bus.p2_use_b && stage_q[i].valid && stage_q[i].write_en &&
             stage_q[i].reg_d == bus.p2_reg_b) begin
            if (i >= int'(stage_q[i].latency)) begin
               sel_b    = SEL_BITS'(i + 1);
               hazard_b = 1'b0;
            end else begin
               sel_b    = '0;
               hazard_b = 1'b1;
            end
         end
      end
   end

   assign kill_p2 = reset || bus.flush;
   assign bubble  = (hazard_a || hazard_b) && bus.p2_valid && !kill_p2;

   assign bus.p2_bubble = bubble;
   assign bus.p2_sel_a  = kill_p2 ? '0 : sel_a;
   assign bus.p2_sel_b  = kill_p2 ? '0 : sel_b;

   // Writes to $0 never create a dependency, so write_en is cleared on entry.
   always_comb begin
      stage_d        = stage_q;
      bubble_count_d = bubble_count_q;
      if (!bus.stall) begin
         stage_d[0].valid    = bus.p2_valid && !bubble && !bus.flush;
         stage_d[0].reg_d    = bus.p2_reg_d;
         stage_d[0].write_en = bus.p2_write_en && (bus.p2_reg_d != 5'd0);
         stage_d[0].latency  = bus.p2_latency;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
            // Only entries younger than the jump die; the jump itself sits further down.
            if (bus.flush && i <= FLUSH_DEPTH) begin
               stage_d[i].valid = 1'b0;
            end
         end
         if (bubble && bubble_count_q != 32'hFFFF_FFFF) begin
            bubble_count_d = bubble_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
         bubble_count_q <= '0;
      end else begin
         stage_q        <= stage_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   assign bus.wb_write_en  = !reset && stage_q[DEPTH-1].valid && stage_q[DEPTH-1].write_en;
   assign bus.wb_reg_d     = (!reset && stage_q[DEPTH-1].valid) ? stage_q[DEPTH-1].reg_d : 5'd0;
   assign bus.bubble_count = bubble_count_q;

endmodule
